// File: rtl/dro_bank_if.sv
// dro_bank_if: pulse/flag bundle between a driver (master) and a dro_bank (slave).
//   set        : per-lane toggle-encoded set pulses
//   readout    : shared toggle-encoded readout pulse
//   flag_clear : level, clears sticky flags on the edge where it is high
//   out        : per-lane toggle-encoded output pulses
//   count      : per-lane stored quanta, lane i at [i*CW +: CW]
//   overflow   : sticky, set arrived at a full lane
//   violation  : sticky, readout too soon after a set on the lane
interface dro_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CW       = 1
);
  logic [CHANNELS-1:0]    set;
  logic                   readout;
  logic                   flag_clear;
  logic [CHANNELS-1:0]    out;
  logic [CHANNELS*CW-1:0] count;
  logic [CHANNELS-1:0]    overflow;
  logic [CHANNELS-1:0]    violation;

  modport master (
    output set, readout, flag_clear,
    input  out, count, overflow, violation
  );

  modport slave (
    input  set, readout, flag_clear,
    output out, count, overflow, violation
  );
endinterface

// File: rtl/dro_bank.sv
// dro_bank: CHANNELS destructive/non-destructive readout storage lanes for
// toggle-encoded SFQ-style pulse models.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : dro_bank_if slave (set/readout/flag_clear in; out/count/flags out)
// Each lane stores up to DEPTH quanta. A readout pulse with quanta stored
// toggles out (and pops one quantum unless NDRO). A set pulse arriving too
// soon before a readout (HOLD_CYCLES) raises a sticky violation flag.
module dro_bank #(
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 1,
  parameter int NDRO        = 0,
  parameter int HOLD_CYCLES = 2,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         rst,
  dro_bank_if.slave   bus
);

  localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  // Bit CHANNELS carries the shared readout, bits below it the set lanes.
  logic [CHANNELS:0]               in_q, prev_q, pulse;
  logic                            arm;
  logic                            rd;
  logic [CHANNELS-1:0]             st;
  logic [CHANNELS-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [CHANNELS-1:0]             out_q, out_d;
  logic [CHANNELS-1:0]             ovf_q, ovf_d;
  logic [CHANNELS-1:0]             vio_q, vio_d;
  logic [CHANNELS-1:0]             hold_vio;

  // Pulses are suppressed until the first post-reset edge has captured the
  // live input levels, so a level held through reset is not seen as a pulse.
  assign pulse = arm ? (in_q ^ prev_q) : '0;
  assign rd    = pulse[CHANNELS];
  assign st    = pulse[CHANNELS-1:0];

  always_comb begin
    logic [CW-1:0] c_rd;
    cnt_d = cnt_q;
    out_d = out_q;
    // A new event in the same cycle as flag_clear leaves the flag set.
    ovf_d = ovf_q & ~{CHANNELS{bus.flag_clear}};
    vio_d = (vio_q & ~{CHANNELS{bus.flag_clear}}) | hold_vio;
    for (int i = 0; i < CHANNELS; i++) begin
      // Readout is evaluated on the pre-set count.
      c_rd = cnt_q[i];
      if (rd && (cnt_q[i] != '0)) begin
        out_d[i] = ~out_q[i];
        if (NDRO == 0) c_rd = cnt_q[i] - CW'(1);
      end
      cnt_d[i] = c_rd;
      if (st[i]) begin
        if (c_rd < CW'(DEPTH)) cnt_d[i] = c_rd + CW'(1);
        else                   ovf_d[i] = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q   <= '0;
      prev_q <= '0;
      arm    <= 1'b0;
      cnt_q  <= '0;
      out_q  <= '0;
      ovf_q  <= '0;
      vio_q  <= '0;
    end else begin
      in_q   <= {bus.readout, bus.set};
      prev_q <= arm ? in_q : {bus.readout, bus.set};
      arm    <= 1'b1;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      vio_q  <= vio_d;
    end
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      logic [CHANNELS-1:0][TW-1:0] tmr_q, tmr_d;
      always_comb begin
        logic [TW-1:0] t_post;
        tmr_d    = tmr_q;
        hold_vio = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          // A set in this cycle restarts the timer before the readout test.
          t_post = st[i] ? '0 : tmr_q[i];
          if (rd && (t_post < TW'(HOLD_CYCLES))) hold_vio[i] = 1'b1;
          tmr_d[i] = (t_post < TW'(HOLD_CYCLES)) ? t_post + TW'(1) : t_post;
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) tmr_q <= {CHANNELS{TW'(HOLD_CYCLES)}};
        else     tmr_q <= tmr_d;
      end
    end else begin : g_no_hold
      assign hold_vio = '0;
    end
  endgenerate

  assign bus.out       = out_q;
  assign bus.count     = cnt_q;
  assign bus.overflow  = ovf_q;
  assign bus.violation = vio_q;

endmodule
